seg_bcd_counter: RTL and testbench

Two-digit decimal up/down counter with debounced push-button inputs that produces the packed two-digit seven-segment pattern consumed by the display multiplexer. It sits directly upstream of the multiplexer:
- Its `both7seg` output drives the multiplexer's `both7seg` input.
- Bits [13:7] carry the tens digit and bits [6:0] carry the ones digit.
- Raw button levels enter asynchronously and are synchronised and debounced internally.

---
 rtl/seg_bcd_counter.sv | 165 ++++++++++++++++
 tb/tb_seg_bcd_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_counter.sv
// Two-digit BCD up/down counter driven by two push buttons.
// Each raw button level is synchronised, debounced, and edge-detected into a
// single-cycle step. The step updates the tens/ones digits, and the digits are
// encoded into a registered pair of seven-segment patterns for the display mux.
module seg_bcd_counter #(
    parameter int DEBOUNCE = 20000,
    parameter int DBITS    = 16,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_btn,
    input  logic        dec_btn,
    input  logic        clear,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic        wrap,
    output logic [13:0] both7seg
);

    // Terminal value of the debounce counter: the state flips on the edge
    // where the counter has already seen DEBOUNCE-1 disagreeing cycles.
    localparam logic [DBITS-1:0] DC_MAX = DBITS'(DEBOUNCE - 1);

    // Reset display shows "00", or " 0" when the leading zero is blanked.
    localparam logic [13:0] RESET_SEG = BLANK_LZ ? 14'h003F : 14'h1FBF;

    // Button index 0 = increment, 1 = decrement.
    logic [1:0] btn_raw;
    logic [1:0] step;

    assign btn_raw = {dec_btn, inc_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             s_reg;
            logic             deb_reg;
            logic             deb_d_reg;
            logic [DBITS-1:0] dc_reg;

            // Synchronise, debounce and delay the debounced level for edge detect.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    s_reg     <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    dc_reg    <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    s_reg     <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (s_reg == deb_reg) begin
                        dc_reg <= '0;
                    end else if (dc_reg == DC_MAX) begin
                        deb_reg <= s_reg;
                        dc_reg  <= '0;
                    end else begin
                        dc_reg <= dc_reg + DBITS'(1);
                    end
                end
            end

            // Only the press (rising debounced edge) counts; release is ignored.
            assign step[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

    logic [3:0]  tens_reg;
    logic [3:0]  ones_reg;
    logic        wrap_reg;
    logic [13:0] seg_reg;
    logic        inc_step;
    logic        dec_step;

    assign inc_step = step[0];
    assign dec_step = step[1];

    // Count update: clear beats steps, and simultaneous inc+dec cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_reg <= 4'd0;
            ones_reg <= 4'd0;
            wrap_reg <= 1'b0;
        end else if (clear) begin
            tens_reg <= 4'd0;
            ones_reg <= 4'd0;
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (inc_step && !dec_step) begin
                if (ones_reg == 4'd9) begin
                    ones_reg <= 4'd0;
                    if (tens_reg == 4'd9) begin
                        tens_reg <= 4'd0;
                        wrap_reg <= 1'b1;
                    end else begin
                        tens_reg <= tens_reg + 4'd1;
                    end
                end else begin
                    ones_reg <= ones_reg + 4'd1;
                end
            end else if (dec_step && !inc_step) begin
                if (ones_reg == 4'd0) begin
                    ones_reg <= 4'd9;
                    if (tens_reg == 4'd0) begin
                        tens_reg <= 4'd9;
                        wrap_reg <= 1'b1;
                    end else begin
                        tens_reg <= tens_reg - 4'd1;
                    end
                end else begin
                    ones_reg <= ones_reg - 4'd1;
                end
            end
        end
    end

    // Active-high segments, bit0 = a ... bit6 = g; non-BCD codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic [6:0] tens_seg_next;
    logic [6:0] ones_seg_next;

    // Encode the current digits, optionally blanking a leading zero.
    always_comb begin
        tens_seg_next = seg7(tens_reg);
        ones_seg_next = seg7(ones_reg);
        if (BLANK_LZ && tens_reg == 4'd0) begin
            tens_seg_next = 7'h00;
        end
    end

    // Register the segment patterns so the display sees glitch-free levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg <= RESET_SEG;
        end else begin
            seg_reg <= {tens_seg_next, ones_seg_next};
        end
    end

    assign tens     = tens_reg;
    assign ones     = ones_reg;
    assign wrap     = wrap_reg;
    assign both7seg = seg_reg;

endmodule

// File: tb/tb_seg_bcd_counter.sv
// Scoreboard bench for seg_bcd_counter. Stimulus tasks drive button presses,
// glitches, clears and resets, and push the expected count events (cycle,
// digits, wrap) into a queue using a plain 0..99 integer model. A monitor
// on the falling edge pops an entry whenever the DUT count changes or wrap
// pulses, and checks the display patterns of a normal and a blanking
// instance every cycle against the expected count of the previous cycle.
module tb_seg_bcd_counter;

    localparam int D = 4;

    typedef struct {
        int at_cyc;
        int t;
        int o;
        int w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc_btn = 1'b0;
    logic        dec_btn = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  tens, ones, tens_b, ones_b;
    logic        wrap, wrap_b;
    logic [13:0] seg, seg_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    int   cur_exp = 0;
    bit   mon_en = 1'b0;
    logic [7:0] last_to = 8'h00;
    exp_t sb_q[$];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_bcd_counter #(.DEBOUNCE(D), .DBITS(16), .BLANK_LZ(1'b0)) u_dut (
        .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .clear(clear), .tens(tens), .ones(ones), .wrap(wrap), .both7seg(seg)
    );

    seg_bcd_counter #(.DEBOUNCE(D), .DBITS(16), .BLANK_LZ(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .clear(clear), .tens(tens_b), .ones(ones_b), .wrap(wrap_b), .both7seg(seg_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
    endtask

    function automatic int exp_seg(input int v, input bit blank);
        logic [6:0] t_p;
        t_p = seg_tab[v / 10];
        if (blank && (v / 10) == 0) t_p = 7'h00;
        return int'({t_p, seg_tab[v % 10]});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int at, input int v, input int w);
        exp_t e;
        e.at_cyc = at;
        e.t = v / 10;
        e.o = v % 10;
        e.w = w;
        sb_q.push_back(e);
    endtask

    // Press inc and/or dec together, hold, optionally clear on the landing edge.
    task automatic press(input bit i, input bit d, input int hold, input bit clr_land);
        int k, nv, w;
        k = cyc;
        inc_btn = i;
        dec_btn = d;
        nv = model_cnt;
        w = 0;
        if (i && !d) begin
            nv = (model_cnt + 1) % 100;
            w = (model_cnt == 99) ? 1 : 0;
        end else if (d && !i) begin
            nv = (model_cnt + 99) % 100;
            w = (model_cnt == 0) ? 1 : 0;
        end
        if (clr_land) begin
            nv = 0;
            w = 0;
        end
        if (nv != model_cnt) push_exp(k + D + 3, nv, w);
        model_cnt = nv;
        if (clr_land) begin
            tick(D + 2);
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
            tick(hold - D - 3);
        end else begin
            tick(hold);
        end
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        tick(D + 5);
    endtask

    task automatic do_clear();
        int k;
        k = cyc;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        if (model_cnt != 0) push_exp(k + 1, 0, 0);
        model_cnt = 0;
        tick(2);
    endtask

    task automatic glitch(input bit which, input int len);
        if (which) dec_btn = 1'b1;
        else inc_btn = 1'b1;
        tick(len);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        tick(D + 4);
    endtask

    // Monitor: display check every cycle, scoreboard pop on each count event.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("both7seg", int'(seg), exp_seg(cur_exp, 1'b0));
            check("both7seg_blank", int'(seg_b), exp_seg(cur_exp, 1'b1));
            if ({tens, ones} != last_to || wrap) begin
                last_to = {tens, ones};
                $display("event cycle=%0d count=%0d%0d wrap=%0d", cyc, tens, ones, wrap);
                if (sb_q.size() == 0) begin
                    check("unexpected_event", int'({tens, ones}), int'(last_to) + 256);
                end else begin
                    e = sb_q.pop_front();
                    check("event_cycle", cyc, e.at_cyc);
                    check("tens", int'(tens), e.t);
                    check("ones", int'(ones), e.o);
                    check("wrap", int'(wrap), e.w);
                    cur_exp = e.t * 10 + e.o;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        exp_t e;
        rst = 1'b1;
        tick(2);
        check("rst_tens", int'(tens), 0);
        check("rst_ones", int'(ones), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_seg", int'(seg), 'h1FBF);
        check("rst_seg_blank", int'(seg_b), 'h003F);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single increment held for 20 cycles: exactly one step.
        press(1'b1, 1'b0, 20, 1'b0);
        // Glitches shorter than the debounce window.
        glitch(1'b0, 3);
        glitch(1'b1, 2);
        // Wrap both ways.
        do_clear();
        press(1'b0, 1'b1, D + 4, 1'b0);
        press(1'b1, 1'b0, D + 4, 1'b0);
        press(1'b0, 1'b1, D + 4, 1'b0);
        // Carry, borrow, simultaneous steps.
        do_clear();
        repeat (19) press(1'b1, 1'b0, D + 4, 1'b0);
        press(1'b1, 1'b0, D + 4, 1'b0);
        press(1'b0, 1'b1, D + 4, 1'b0);
        press(1'b1, 1'b1, D + 4, 1'b0);
        // Up to 42, then clear on the landing edge of an inc step.
        repeat (23) press(1'b1, 1'b0, D + 4, 1'b0);
        press(1'b1, 1'b0, D + 6, 1'b1);
        // Count 07 exercises leading-zero blanking.
        repeat (7) press(1'b1, 1'b0, D + 4, 1'b0);
        tick(3);
        // Button held through a reset that lands mid-debounce.
        do_clear();
        k = cyc;
        inc_btn = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push_exp(k + D + 7, 1, 0);
        model_cnt = 1;
        tick(D + 8);
        inc_btn = 1'b0;
        tick(D + 5);

        // Randomised operations.
        repeat (80) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: press(1'b1, 1'b0, D + 4 + int'($urandom_range(0, 8)), 1'b0);
                4, 5, 6:    press(1'b0, 1'b1, D + 4 + int'($urandom_range(0, 8)), 1'b0);
                7:          press(1'b1, 1'b1, D + 4 + int'($urandom_range(0, 8)), 1'b0);
                8:          glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, D - 1)));
                default: begin
                    if ($urandom_range(0, 1) == 0) do_clear();
                    else press(1'b1, 1'b0, D + 6, 1'b1);
                end
            endcase
        end

        tick(10);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("missing_event_cycle", cyc, e.at_cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
